cmul_scheduler: RTL

- Sequences one shared signed fixed-point real multiplier (Q-format, N bits, Q fraction bits) to compute one complex product per transaction, e.g. FFT twiddle multiply.
- Accepts operand pair A, B over a valid/ready handshake and issues the four real products to the multiplier on consecutive cycles.
- Captures the four results, combines them into Re/Im and presents the result over a valid/ready handshake.
- Sits between the butterfly control and the single multiplier instance, so the butterfly datapath needs only one multiplier.

---
 rtl/cmul_scheduler.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cmul_scheduler.sv
// Complex multiply sequencer: drives one shared real multiplier with the four
// partial products of A*B and combines them into Re/Im behind valid/ready.
module cmul_scheduler #(
  parameter int N       = 16,
  parameter int Q       = 8,
  parameter int MUL_LAT = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_ar,
  input  logic [N-1:0] i_ai,
  input  logic [N-1:0] i_br,
  input  logic [N-1:0] i_bi,
  output logic [N-1:0] o_mul_a,
  output logic [N-1:0] o_mul_b,
  input  logic [N-1:0] i_mul_c,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_cr,
  output logic [N-1:0] o_ci
);

  if (MUL_LAT < 1 || MUL_LAT > 4 || Q >= N) begin : g_bad_param
    $error("cmul_scheduler: MUL_LAT must be 1..4 and Q below N");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  state_t              state;
  logic signed [N-1:0] ar, ai, br, bi;
  logic [1:0]          k;
  logic [1:0]          cap;
  logic [MUL_LAT-1:0]  iss_sr;
  logic signed [N-1:0] prod [3];
  logic                capture;

  // iss_sr mirrors the multiplier pipeline: its tail marks a valid i_mul_c
  assign capture = iss_sr[MUL_LAT-1];

  function automatic logic signed [N-1:0] wrap_sub(input logic signed [N-1:0] a,
                                                   input logic signed [N-1:0] b);
    return a - b;
  endfunction

  function automatic logic signed [N-1:0] wrap_add(input logic signed [N-1:0] a,
                                                   input logic signed [N-1:0] b);
    return a + b;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_cr    <= '0;
      o_ci    <= '0;
      o_mul_a <= '0;
      o_mul_b <= '0;
      ar      <= '0;
      ai      <= '0;
      br      <= '0;
      bi      <= '0;
      k       <= '0;
      cap     <= '0;
      iss_sr  <= '0;
      for (int i = 0; i < 3; i++) prod[i] <= '0;
    end else begin
      iss_sr[0] <= (state == ISSUE);
      for (int i = 1; i < MUL_LAT; i++) iss_sr[i] <= iss_sr[i-1];

      if (capture) begin
        cap <= cap + 2'd1;
        if (cap != 2'd3) prod[cap] <= i_mul_c;
      end

      case (state)
        IDLE: begin
          if (i_valid) begin
            ar      <= i_ar;
            ai      <= i_ai;
            br      <= i_br;
            bi      <= i_bi;
            k       <= '0;
            cap     <= '0;
            o_mul_a <= i_ar;
            o_mul_b <= i_br;
            o_ready <= 1'b0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          k <= k + 2'd1;
          case (k)
            2'd0: begin o_mul_a <= ai; o_mul_b <= bi; end
            2'd1: begin o_mul_a <= ar; o_mul_b <= bi; end
            2'd2: begin o_mul_a <= ai; o_mul_b <= br; end
            default: begin
              o_mul_a <= '0;
              o_mul_b <= '0;
              state   <= DRAIN;
            end
          endcase
        end
        DRAIN: begin
          // the fourth product is taken straight from the multiplier
          if (capture && cap == 2'd3) begin
            o_cr    <= wrap_sub(prod[0], prod[1]);
            o_ci    <= wrap_add(prod[2], i_mul_c);
            o_valid <= 1'b1;
            state   <= OUT;
          end
        end
        OUT: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
